// File: rtl/uart_pkg.sv
// Shared UART loopback types and defaults.
// The RX and TX benches reuse the defaults so they stay consistent with the buffer.
package uart_pkg;

  localparam int unsigned BYTE_W               = 8;
  localparam int unsigned DEFAULT_DEPTH        = 16;
  localparam int unsigned DEFAULT_BUSY_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_IDLE
  } loop_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with a registered read port.
// Push is refused when full and pop is refused when empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_din,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_dout,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [BYTE_W-1:0] r_dout;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_dout;
  assign o_count = r_count;

endmodule

// File: rtl/uart_loop_fifo.sv
// Loopback buffer between UART RX and TX: queues received bytes and hands the
// oldest one to the transmitter with a one-cycle tx_en whenever it is idle.
module uart_loop_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_tx_busy,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic              o_tx_en,
  output logic [CNT_W-1:0]  o_fifo_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int unsigned      TMO_W    = $clog2(BUSY_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  loop_state_t      r_state;
  loop_state_t      w_state_next;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_next;
  logic             r_tx_en;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  // Full is the registered flag, so a same-cycle pop never makes room for a push.
  assign w_push = i_rx_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty && !i_tx_busy;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_byte_fifo (
    .i_clk   (i_sys_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (i_rx_data),
    .i_pop   (w_pop),
    .o_dout  (o_tx_data),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A byte whose busy never shows up within the timeout is treated as sent.
  always_comb begin
    w_state_next = r_state;
    w_tmo_next   = r_tmo;
    unique case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_next = WAIT_BUSY;
          w_tmo_next   = '0;
        end
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_next = WAIT_IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!i_tx_busy) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_tmo      <= '0;
      r_tx_en    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
      r_tx_en <= w_pop;
      if (i_rx_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_tx_en    = r_tx_en;
  assign o_overflow = r_overflow;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Directed self-checking bench for uart_loop_fifo (DEPTH=16, BUSY_TIMEOUT=8).
module tb_uart_loop_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [4:0] fifo_count;
  logic       full;
  logic       empty;
  logic       overflow;

  int         n_cmp = 0;
  int         n_err = 0;
  int         busy_left = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  uart_loop_fifo dut (
    .i_sys_clk    (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_tx_busy    (tx_busy),
    .o_tx_data    (tx_data),
    .o_tx_en      (tx_en),
    .o_fifo_count (fifo_count),
    .o_full       (full),
    .o_empty      (empty),
    .o_overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with a transmitter model: busy high for 10 cycles after each tx_en.
  task automatic tx_cycle();
    tick();
    if (tx_en === 1'b1) begin
      got.push_back(tx_data);
      busy_left = 10;
    end
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; busy_left = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; busy_left = 0;
    tick();
    tick();
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full); end
    n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL rst_tx_en got %b want 0", tx_en); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    rx_valid = 1'b1; rx_data = 8'hA5;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL lat_count_k got %0d want 1", fifo_count); end
    n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL lat_tx_en_k got %b want 0", tx_en); end
    tick();
    n_cmp++; if (tx_en !== 1'b1) begin n_err++; $display("FAIL lat_tx_en_k1 got %b want 1", tx_en); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL lat_tx_data got %h want a5", tx_data); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL lat_count_k1 got %0d want 0", fifo_count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL lat_empty got %b want 1", empty); end
    tick();
    n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL lat_tx_en_k2 got %b want 0", tx_en); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL lat_hold got %h want a5", tx_data); end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i);
      tick();
      if (i == 15) begin
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full16 got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    rx_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL ovf_no_pop got %b want 0", tx_en); end
    got.delete();
    tx_busy = 1'b0; busy_left = 0;
    repeat (260) tx_cycle();
    n_cmp++; if (got.size() != 16) begin n_err++; $display("FAIL ovf_emitted got %0d want 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_cmp++;
      if (got[i] !== 8'(i)) begin n_err++; $display("FAIL ovf_order[%0d] got %h want %h", i, got[i], 8'(i)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain got %b want 1", empty); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b;
    do_reset();
    got.delete();
    for (int i = 0; i < 40; i++) begin
      rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
      tx_cycle();
      rx_valid = 1'b0;
      repeat (19) tx_cycle();
    end
    n_cmp++; if (got.size() != 40) begin n_err++; $display("FAIL wrap_emitted got %0d want 40", got.size()); end
    for (int i = 0; i < got.size() && i < 40; i++) begin
      exp_b = 8'h40 + 8'(i);
      n_cmp++;
      if (got[i] !== exp_b) begin n_err++; $display("FAIL wrap_order[%0d] got %h want %h", i, got[i], exp_b); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow got %b want 0", overflow); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL wrap_count got %0d want 0", fifo_count); end
  endtask

  // Busy never rises: pops at edges P, P+9, P+18 (8 cycles in WAIT_BUSY each).
  task automatic test_timeout();
    int         at_c[$];
    logic [7:0] at_d[$];
    logic [4:0] at_n[$];
    int         exp_c[3];
    logic [7:0] exp_d[3];
    logic [4:0] exp_n[3];
    exp_c = '{1, 10, 19};
    exp_d = '{8'hB0, 8'hB1, 8'hB2};
    exp_n = '{5'd2, 5'd1, 5'd0};
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'hB0 + 8'(i);
      tick();
    end
    rx_valid = 1'b0; tx_busy = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (tx_en === 1'b1) begin
        at_c.push_back(c); at_d.push_back(tx_data); at_n.push_back(fifo_count);
      end
    end
    n_cmp++; if (at_c.size() != 3) begin n_err++; $display("FAIL tmo_pops got %0d want 3", at_c.size()); end
    for (int i = 0; i < at_c.size() && i < 3; i++) begin
      n_cmp++;
      if (at_c[i] != exp_c[i]) begin n_err++; $display("FAIL tmo_cycle[%0d] got %0d want %0d", i, at_c[i], exp_c[i]); end
      n_cmp++;
      if (at_d[i] !== exp_d[i]) begin n_err++; $display("FAIL tmo_data[%0d] got %h want %h", i, at_d[i], exp_d[i]); end
      n_cmp++;
      if (at_n[i] !== exp_n[i]) begin n_err++; $display("FAIL tmo_count[%0d] got %0d want %0d", i, at_n[i], exp_n[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int extra;
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'hC0 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd3) begin n_err++; $display("FAIL mid_count3 got %0d want 3", fifo_count); end
    tx_busy = 1'b0; rx_valid = 1'b1; rx_data = 8'hC3;
    tick();
    rx_valid = 1'b0; tx_busy = 1'b1;
    n_cmp++; if (fifo_count !== 5'd3) begin n_err++; $display("FAIL mid_pushpop got %0d want 3", fifo_count); end
    n_cmp++; if (tx_en !== 1'b1) begin n_err++; $display("FAIL mid_tx_en got %b want 1", tx_en); end
    n_cmp++; if (tx_data !== 8'hC0) begin n_err++; $display("FAIL mid_tx_data got %h want c0", tx_data); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; tx_busy = 1'b0;
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", fifo_count); end
    n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_en got %b want 0", tx_en); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_tx_data got %h want 00", tx_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_overflow got %b want 0", overflow); end
    extra = 0;
    repeat (20) begin
      tick();
      if (tx_en !== 1'b0) extra++;
    end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL mid_no_tx got %0d pulses want 0", extra); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", empty); end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    test_reset();
    test_latency();
    test_overflow();
    test_reset();
    test_wrap();
    test_timeout();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
